// File: rtl/ws2812_decoder.sv
// WS2812 single-wire receiver: decodes a 3-LED GRB frame and presents it on each latch gap.
module ws2812_decoder #(
    parameter int unsigned CLOCK_FREQUENCY = 80000000,
    parameter int unsigned THRESHOLD_NS    = 600,
    parameter int unsigned MAX_HIGH_NS     = 2000,
    parameter int unsigned RESET_US        = 50
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       i_Din,
    output logic [7:0] o_LED1_R,
    output logic [7:0] o_LED1_G,
    output logic [7:0] o_LED1_B,
    output logic [7:0] o_LED2_R,
    output logic [7:0] o_LED2_G,
    output logic [7:0] o_LED2_B,
    output logic [7:0] o_LED3_R,
    output logic [7:0] o_LED3_G,
    output logic [7:0] o_LED3_B,
    output logic       o_Frame_Valid,
    output logic       o_Error,
    output logic       o_Busy
);

    localparam int unsigned CYC_PER_US   = CLOCK_FREQUENCY / 1000000;
    localparam int unsigned THRESH_CYC   = CYC_PER_US * THRESHOLD_NS / 1000;
    localparam int unsigned MAX_HIGH_CYC = CYC_PER_US * MAX_HIGH_NS / 1000;
    localparam int unsigned RESET_CYC    = CYC_PER_US * RESET_US;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned BIT_W        = 5;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned WORD_W       = 24;
    localparam int unsigned NUM_LEDS     = 3;

    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH_CYC);
    // low_cnt reaches RESET_CYC on the edge where this value is incremented
    localparam logic [CNT_W-1:0] LATCH_C    = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(NUM_LEDS);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    typedef enum logic [1:0] {
        GAP_WAIT = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                              sync1_q;
    logic                              din_s_q;
    logic                              din_prev_q;
    logic [CNT_W-1:0]                  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]                  low_cnt_q, low_cnt_d;
    logic [BIT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]                  led_idx_q, led_idx_d;
    logic                              overrun_q, overrun_d;
    logic [WORD_W-1:0]                 shift_q, shift_d;
    logic [NUM_LEDS-1:0][WORD_W-1:0]   staging_q, staging_d;
    logic [NUM_LEDS-1:0][WORD_W-1:0]   led_q, led_d;
    logic                              valid_pend_q, valid_pend_d;
    logic                              frame_valid_q, frame_valid_d;
    logic                              error_q, error_d;
    logic                              busy_q, busy_d;

    logic              rise_c;
    logic              fall_c;
    logic              too_long_c;
    logic              latch_c;
    logic              gap_done_c;
    logic              frame_ok_c;
    logic              bit_val_c;
    logic [WORD_W-1:0] shift_next_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q    <= 1'b0;
            din_s_q    <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            sync1_q    <= i_Din;
            din_s_q    <= sync1_q;
            din_prev_q <= din_s_q;
        end
    end

    assign rise_c       = din_s_q & ~din_prev_q;
    assign fall_c       = ~din_s_q & din_prev_q;
    assign too_long_c   = (high_cnt_q > MAX_HIGH_C);
    assign latch_c      = (state_q == LOW) && (low_cnt_q == LATCH_C);
    assign gap_done_c   = ~din_s_q && (low_cnt_q == LATCH_C);
    assign frame_ok_c   = (led_idx_q == IDX_FULL) && (bit_cnt_q == '0) && ~overrun_q;
    assign bit_val_c    = (high_cnt_q >= THRESH_C);
    assign shift_next_c = {shift_q[WORD_W-2:0], bit_val_c};

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= GAP_WAIT;
        else       state_q <= state_d;
    end

    // Next-state logic; latch wins over a coincident rising edge, which then starts the next frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            GAP_WAIT: if (gap_done_c) state_d = IDLE;
            IDLE:     if (rise_c)     state_d = HIGH;
            HIGH: begin
                if (too_long_c)  state_d = GAP_WAIT;
                else if (fall_c) state_d = LOW;
            end
            LOW: begin
                if (latch_c)     state_d = rise_c ? HIGH : IDLE;
                else if (rise_c) state_d = HIGH;
            end
            default:             state_d = GAP_WAIT;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        led_idx_d     = led_idx_q;
        overrun_d     = overrun_q;
        shift_d       = shift_q;
        staging_d     = staging_q;
        led_d         = led_q;
        valid_pend_d  = 1'b0;
        frame_valid_d = valid_pend_q;
        error_d       = 1'b0;
        busy_d        = (state_d == HIGH) || (state_d == LOW);
        case (state_q)
            GAP_WAIT: low_cnt_d = din_s_q ? '0 : sat_inc(low_cnt_q);
            IDLE: begin
                if (rise_c) high_cnt_d = CNT_ONE;
            end
            HIGH: begin
                high_cnt_d = sat_inc(high_cnt_q);
                if (too_long_c) begin
                    error_d   = 1'b1;
                    staging_d = '0;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    led_idx_d = '0;
                    overrun_d = 1'b0;
                    low_cnt_d = '0;
                end else if (fall_c) begin
                    low_cnt_d = CNT_ONE;
                    if (led_idx_q == IDX_FULL) begin
                        overrun_d = 1'b1;
                    end else begin
                        shift_d = shift_next_c;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d            = '0;
                            staging_d[led_idx_q] = shift_next_c;
                            led_idx_d            = led_idx_q + IDX_ONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end
            end
            LOW: begin
                low_cnt_d = sat_inc(low_cnt_q);
                if (latch_c) begin
                    if (frame_ok_c) begin
                        led_d        = staging_q;
                        valid_pend_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    led_idx_d = '0;
                    overrun_d = 1'b0;
                    if (rise_c) high_cnt_d = CNT_ONE;
                end else if (rise_c) begin
                    high_cnt_d = CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            led_idx_q     <= '0;
            overrun_q     <= 1'b0;
            shift_q       <= '0;
            staging_q     <= '0;
            led_q         <= '0;
            valid_pend_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            led_idx_q     <= led_idx_d;
            overrun_q     <= overrun_d;
            shift_q       <= shift_d;
            staging_q     <= staging_d;
            led_q         <= led_d;
            valid_pend_q  <= valid_pend_d;
            frame_valid_q <= frame_valid_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
        end
    end

    // Staging slot word layout is G[23:16], R[15:8], B[7:0]
    assign o_LED1_G      = led_q[0][23:16];
    assign o_LED1_R      = led_q[0][15:8];
    assign o_LED1_B      = led_q[0][7:0];
    assign o_LED2_G      = led_q[1][23:16];
    assign o_LED2_R      = led_q[1][15:8];
    assign o_LED2_B      = led_q[1][7:0];
    assign o_LED3_G      = led_q[2][23:16];
    assign o_LED3_R      = led_q[2][15:8];
    assign o_LED3_B      = led_q[2][7:0];
    assign o_Frame_Valid = frame_valid_q;
    assign o_Error       = error_q;
    assign o_Busy        = busy_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Scoreboard bench for ws2812_decoder: stimulus pushes expected pulses, a monitor pops and compares.
module tb_ws2812_decoder;

    localparam int unsigned RESET_CYC = 4000;
    localparam int unsigned SYNC_LAT  = 2;
    localparam int unsigned GAP       = 4000;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       i_Din;
    logic [7:0] o_LED1_R, o_LED1_G, o_LED1_B;
    logic [7:0] o_LED2_R, o_LED2_G, o_LED2_B;
    logic [7:0] o_LED3_R, o_LED3_G, o_LED3_B;
    logic       o_Frame_Valid, o_Error, o_Busy;

    ws2812_decoder dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .i_Din         (i_Din),
        .o_LED1_R      (o_LED1_R),
        .o_LED1_G      (o_LED1_G),
        .o_LED1_B      (o_LED1_B),
        .o_LED2_R      (o_LED2_R),
        .o_LED2_G      (o_LED2_G),
        .o_LED2_B      (o_LED2_B),
        .o_LED3_R      (o_LED3_R),
        .o_LED3_G      (o_LED3_G),
        .o_LED3_B      (o_LED3_B),
        .o_Frame_Valid (o_Frame_Valid),
        .o_Error       (o_Error),
        .o_Busy        (o_Busy)
    );

    always #5 Clock = ~Clock;

    longint cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [71:0] leds;
        longint      at;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint last_fall = 0;

    // Hand-computed frames, GRB words per LED, LED1 first
    localparam logic [71:0] F1  = {24'h001100, 24'h110000, 24'h000011};
    localparam logic [71:0] F2B = {24'h800000, 24'h000000, 24'h000000};
    localparam logic [71:0] F5  = {24'h123456, 24'hABCDEF, 24'h0F0F0F};
    localparam logic [71:0] F3  = {24'hFFFFFF, 24'h00FF00, 24'h000000};
    localparam logic [71:0] F4  = {24'hAAAAAA, 24'h555555, 24'hF0F0F0};

    function automatic logic [71:0] leds_now();
        return {o_LED1_G, o_LED1_R, o_LED1_B, o_LED2_G, o_LED2_R, o_LED2_B,
                o_LED3_G, o_LED3_R, o_LED3_B};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_valid(input logic [71:0] leds);
        exp_t e;
        e.is_err = 1'b0;
        e.leds   = leds;
        e.at     = last_fall + longint'(RESET_CYC) + 1 + longint'(SYNC_LAT);
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [71:0] leds);
        exp_t e;
        e.is_err = 1'b1;
        e.leds   = leds;
        e.at     = 0;
        exp_q.push_back(e);
    endtask

    // Send nbits MSB-first from a left-aligned 73-bit word; hi0 overrides the first bit's high time
    task automatic send_bits(input logic [72:0] data, input int nbits, input int period, input int hi0);
        for (int i = 0; i < nbits; i++) begin
            int hi;
            hi = data[72 - i] ? 64 : 32;
            if (i == 0 && hi0 != 0) hi = hi0;
            i_Din = 1'b1;
            repeat (hi) @(negedge Clock);
            i_Din = 1'b0;
            last_fall = cyc;
            repeat (period - hi) @(negedge Clock);
        end
    endtask

    task automatic gap(input int n);
        i_Din = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge Clock) begin
        if (!Reset && (o_Frame_Valid || o_Error)) begin
            if (o_Frame_Valid && o_Error) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_pulses: valid and error high together at cycle %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b at cycle %0d, expected none",
                         o_Frame_Valid, o_Error, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_is_error", 72'(o_Error), 72'(e.is_err));
                check("leds_at_pulse", leds_now(), e.leds);
                if (!e.is_err) check("valid_latency", 72'(cyc), 72'(e.at));
            end
        end
    end

    initial begin
        Reset = 1'b1;
        i_Din = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_leds", leds_now(), 72'h0);
        check("reset_valid", 72'(o_Frame_Valid), 72'h0);
        check("reset_error", 72'(o_Error), 72'h0);
        check("reset_busy", 72'(o_Busy), 72'h0);
        Reset = 1'b0;
        gap(GAP);

        // 1: basic frame with the 100-cycle bit timing, latency checked in the monitor
        send_bits({F1, 1'b0}, 72, 100, 0);
        push_valid(F1);
        gap(GAP);
        check("t1_leds", leds_now(), F1);
        check("t1_busy_idle", 72'(o_Busy), 72'h0);

        // 3: short frame of 48 bits
        push_err(F1);
        send_bits({F3, 1'b0}, 48, 80, 0);
        gap(GAP);

        // 4: overlong frame of 73 bits
        push_err(F1);
        send_bits({F4, 1'b1}, 73, 80, 0);
        gap(GAP);
        check("t4_leds_kept", leds_now(), F1);

        // 2: threshold on the very first bit
        send_bits(73'h0, 72, 80, 47);
        push_valid(72'h0);
        gap(GAP);
        send_bits(73'h0, 72, 80, 48);
        push_valid(F2B);
        gap(GAP);
        check("t2_msb_g1", 72'(o_LED1_G[7]), 72'h1);

        // 5: overlong high pulse, then a frame without a full gap is ignored
        push_err(F2B);
        i_Din = 1'b1;
        repeat (161) @(negedge Clock);
        gap(1000);
        send_bits({F5, 1'b0}, 72, 80, 0);
        gap(GAP);
        check("t5_ignored", leds_now(), F2B);
        send_bits({F5, 1'b0}, 72, 80, 0);
        push_valid(F5);
        gap(GAP);

        // 6: reset in the middle of a frame
        send_bits({F1, 1'b0}, 30, 80, 0);
        check("t6_busy_mid", 72'(o_Busy), 72'h1);
        Reset = 1'b1;
        #1;
        check("t6_reset_leds", leds_now(), 72'h0);
        check("t6_reset_busy", 72'(o_Busy), 72'h0);
        @(negedge Clock);
        Reset = 1'b0;
        send_bits({F5, 1'b0}, 72, 80, 0);
        gap(GAP);
        check("t6_no_frame", leds_now(), 72'h0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge Clock);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: not observed, expected error=%0b leds=%h", e.is_err, e.leds);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_decoder.md
Name: ws2812_decoder

Overview:
Receive-side counterpart of the WS2812 LED driver. Samples a single-wire WS2812 NRZ stream and decodes the 72-bit frame for the 3-LED chain (24 bits per LED, GRB order, MSB first). On each latch gap it presents the decoded R/G/B bytes for all three LEDs. Used for driver loopback and in-system self-test of the LED path.

Parameters:
CLOCK_FREQUENCY, 80000000, system clock in Hz.
THRESHOLD_NS, 600, a high pulse of at least this length decodes as 1; a shorter one decodes as 0.
MAX_HIGH_NS, 2000, a high pulse longer than this is a line error.
RESET_US, 50, a low period of at least this length is the latch gap.
Derived: THRESH_CYC = CLOCK_FREQUENCY/1e6*THRESHOLD_NS/1000 (48); MAX_HIGH_CYC (160); RESET_CYC = CLOCK_FREQUENCY/1e6*RESET_US (4000).

Ports:
Clock  in  1  system clock
Reset  in  1  reset, asynchronous, active-high
i_Din  in  1  WS2812 data line, asynchronous to Clock
o_LED1_R, o_LED1_G, o_LED1_B  out  8 each  decoded LED1 colour bytes
o_LED2_R, o_LED2_G, o_LED2_B  out  8 each  decoded LED2 colour bytes
o_LED3_R, o_LED3_G, o_LED3_B  out  8 each  decoded LED3 colour bytes
o_Frame_Valid  out  1  one-cycle pulse when the LED outputs update
o_Error  out  1  one-cycle pulse on a malformed frame or line error
o_Busy  out  1  high while a frame is being received

Behaviour:
- Input path: 2-flop synchroniser on i_Din. All edge detection and counting use the synchronised signal (din_s); pin-to-din_s latency is 2 cycles.
- Reset: all o_LED* = 0x00; o_Frame_Valid, o_Error and o_Busy = 0; staging registers cleared; state = GAP_WAIT.
- Counters: high_cnt and low_cnt are 16 bits and saturate at all-ones (no wrap). bit_cnt is 5 bits (0..23). led_idx is 2 bits (0..3).
- GAP_WAIT: low_cnt counts consecutive low cycles. A high cycle clears low_cnt. When low_cnt reaches RESET_CYC, go to IDLE. No bits are decoded in this state, so decoding never starts mid-frame.
- IDLE: o_Busy = 0. A rising edge on din_s sets high_cnt = 1 and goes to HIGH.
- HIGH: o_Busy = 1 and high_cnt increments each cycle.
  - If high_cnt exceeds MAX_HIGH_CYC: pulse o_Error, discard staging, go to GAP_WAIT.
  - On a falling edge: bit = (high_cnt >= THRESH_CYC). Shift bit into the 24-bit shift register MSB first, increment bit_cnt, set low_cnt = 1, go to LOW.
  - When bit_cnt wraps 23->0, write shift[23:16]=G, [15:8]=R, [7:0]=B into staging slot led_idx, then increment led_idx.
  - If a 73rd bit arrives (led_idx = 3), set an internal overrun flag. The bit is not stored.
- LOW: low_cnt increments each cycle.
  - A rising edge before RESET_CYC sets high_cnt = 1 and goes to HIGH.
  - When low_cnt = RESET_CYC (latch), check the frame:
    - led_idx = 3, bit_cnt = 0 and no overrun: copy all staging registers to the o_LED* outputs in that cycle and pulse o_Frame_Valid on the following cycle.
    - Otherwise: pulse o_Error; o_LED* keep their previous values.
  - In either case clear bit_cnt, led_idx and overrun, then go to IDLE.
- o_Frame_Valid latency: asserted RESET_CYC+1 cycles after the din_s falling edge of the last bit. o_LED* are stable from the same cycle o_Frame_Valid rises and hold until the next valid frame.
- Simultaneous events: the MAX_HIGH error check takes priority over the falling edge in the same cycle. The latch decision takes priority over a rising edge in the same cycle; that edge is then treated as IDLE's start of the next frame.
- Reset mid-frame: all state and outputs clear immediately. A full RESET_CYC low gap is required before the next frame is accepted.
- o_Frame_Valid and o_Error are never high in the same cycle.

Test Plan:
1. Reset, hold the line low for 4000 cycles, then send a 72-bit frame (0 = 32 cycles high + 68 low, 1 = 64 high + 36 low) with GRB words 0x001100, 0x110000, 0x000011, followed by a 4000-cycle low. Required: o_LED1_R = 0x11, o_LED2_G = 0x11, o_LED3_B = 0x11, all other bytes 0x00, and exactly one o_Frame_Valid pulse at RESET_CYC+1 cycles after the last falling edge.
2. Threshold: a frame whose bit 0 is 47 cycles high decodes that bit as 0; the same frame with 48 cycles decodes it as 1. Required: the MSB of o_LED1_G toggles accordingly.
3. Send only 48 bits, then the gap. Required: one o_Error pulse, no o_Frame_Valid, o_LED* unchanged from scenario 1.
4. Send 73 bits, then the gap. Required: o_Error pulse, o_LED* unchanged.
5. Hold a high pulse for 161 cycles. Required: o_Error pulse. A valid frame sent after only 1000 low cycles is ignored (no pulse). The same frame sent after a 4000-cycle gap produces o_Frame_Valid.
6. Assert Reset after 30 bits of a frame. Required: o_LED* = 0 and o_Busy = 0 immediately, and a frame sent right after deassertion without a gap produces no o_Frame_Valid.
